// File: rtl/isp_color_pkg.sv
// Shared colour-space constants and fixed-point types for the ISP colour stages.
// YCbCr pixels are signed 9.9. Coefficients are signed Q2.15. Products carry 24 fractional bits.
package isp_color_pkg;

    localparam int PIX_W     = 18;
    localparam int FRAC_IN   = 9;
    localparam int COEF_FRAC = 15;
    localparam int COEF_W    = 18;
    localparam int PROD_W    = PIX_W + COEF_W;
    localparam int SUM_W     = PROD_W + 2;
    localparam int PROD_FRAC = FRAC_IN + COEF_FRAC;
    localparam int INT_W     = SUM_W - PROD_FRAC;
    localparam int OUT_W     = 8;
    localparam int NUM_CH    = 3;

    typedef logic signed [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef logic signed [INT_W-1:0]  int_t;

    // Row-major R,G,B x Y,Cb,Cr; element 0 is R<-Y.
    localparam logic [0:NUM_CH*NUM_CH-1][COEF_W-1:0] YCC2RGB_COEF = {
        18'sd32768,  18'sd0,       18'sd45941,
        18'sd32768, -18'sd11277,  -18'sd23401,
        18'sd32768,  18'sd58065,   18'sd0
    };

    // Half an output LSB, giving round-half-up before truncation.
    localparam sum_t ROUND_K = sum_t'(1) << (PROD_FRAC - 1);

    localparam int_t U8_MAX = int_t'(255);

endpackage

// File: rtl/sat_round_u8.sv
// Rounds a 24-fractional-bit signed channel sum to an integer and clamps it to 0..255.
import isp_color_pkg::*;

module sat_round_u8 (
    input  logic signed [SUM_W-1:0] sum_i,
    output logic [OUT_W-1:0]        u8_o
);

    sum_t rounded;
    int_t int_part;

    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        rounded  = sum_i + ROUND_K;
        int_part = rounded[SUM_W-1:PROD_FRAC];
        u8_o     = int_part[OUT_W-1:0];
        if (int_part[INT_W-1]) begin
            u8_o = '0;
        end else if (int_part > U8_MAX) begin
            u8_o = '1;
        end
    end

endmodule

// File: rtl/ycc2rgb_stream.sv
// Four-stage streaming YCbCr (signed 9.9) to packed RGB888 converter with frame-done pulse.
// The stages are input register, nine products, three channel sums, then round and clamp.
module ycc2rgb_stream
    import isp_color_pkg::*;
#(
    parameter int width     = 320,
    parameter int height    = 240,
    parameter int frameSize = width * height
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iValid,
    input  logic signed [PIX_W-1:0]   iY,
    input  logic signed [PIX_W-1:0]   iCb,
    input  logic signed [PIX_W-1:0]   iCr,
    output logic [NUM_CH*OUT_W-1:0]   oData,
    output logic                      oValid,
    output logic                      oDone
);

    localparam int CNT_W = (frameSize > 1) ? $clog2(frameSize) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(frameSize - 1);

    // S1 input registers, indexed Y, Cb, Cr
    pix_t pix_q [NUM_CH];

    // NOTE: datapath registers carry no reset; only the valid bits and outputs need a defined state, and this keeps reset fan-out off the wide pipeline.
    always_ff @(posedge clk) begin
        pix_q[0] <= iY;
        pix_q[1] <= iCb;
        pix_q[2] <= iCr;
    end

    logic [OUT_W-1:0] chan_u8 [NUM_CH];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        prod_t prod_d [NUM_CH];
        prod_t prod_q [NUM_CH];
        sum_t  sum_d;
        sum_t  sum_q;

        always_comb begin
            for (int comp = 0; comp < NUM_CH; comp++) begin
                prod_d[comp] = prod_t'(pix_q[comp])
                             * prod_t'(coef_t'(YCC2RGB_COEF[ch*NUM_CH + comp]));
            end
            sum_d = sum_t'(prod_q[0]) + sum_t'(prod_q[1]) + sum_t'(prod_q[2]);
        end

        always_ff @(posedge clk) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end

        sat_round_u8 u_sat (
            .sum_i (sum_q),
            .u8_o  (chan_u8[ch])
        );
    end

    logic [2:0]              vld_q, vld_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*OUT_W-1:0] odata_q, odata_d;
    logic                    ovalid_q, ovalid_d;
    logic                    odone_q, odone_d;

    always_comb begin
        vld_d    = {vld_q[1:0], iValid};
        ovalid_d = vld_q[2];
        odata_d  = odata_q;
        if (vld_q[2]) begin
            odata_d = {chan_u8[0], chan_u8[1], chan_u8[2]};
        end

        // Counter wraps on the last pixel so oDone lands the cycle after its oValid.
        cnt_d   = cnt_q;
        odone_d = 1'b0;
        if (ovalid_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                odone_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q    <= '0;
            cnt_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            odone_q  <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            odone_q  <= odone_d;
        end
    end

    assign oData  = odata_q;
    assign oValid = ovalid_q;
    assign oDone  = odone_q;

endmodule

// File: tb/tb_ycc2rgb_stream.sv
// Self-checking bench for ycc2rgb_stream. It uses directed colour points, frame counting, reset abort
// and a random stream. All of these are checked against an arithmetic reference model.
module tb_ycc2rgb_stream;

    localparam int FRAME = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               iValid;
    logic signed [17:0] iY, iCb, iCr;
    logic [23:0]        oData;
    logic               oValid;
    logic               oDone;

    ycc2rgb_stream #(.width(4), .height(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .iValid (iValid),
        .iY     (iY),
        .iCb    (iCb),
        .iCr    (iCr),
        .oData  (oData),
        .oValid (oValid),
        .oDone  (oDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the real-valued conversion, floor(x + 0.5), clamp.
    function automatic logic [23:0] ref_rgb(input logic signed [17:0] y, cb, cr);
        longint k [3][3] = '{'{32768, 0, 45941}, '{32768, -11277, -23401}, '{32768, 58065, 0}};
        longint acc, v;
        logic [23:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            acc = longint'(y) * k[c][0] + longint'(cb) * k[c][1] + longint'(cr) * k[c][2];
            v   = (acc + 64'sd8388608) >>> 24;
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            r[23 - 8*c -: 8] = v[7:0];
        end
        return r;
    endfunction

    typedef struct {
        logic [23:0] rgb;
        int          stamp;
    } exp_t;

    exp_t        exp_q [$];
    int          out_cnt      = 0;
    bit          done_pending = 0;
    bit          prev_valid   = 0;
    logic [23:0] last_data    = '0;
    int          done_seen    = 0;

    // Output monitor: pixel value, exact 4-cycle latency, hold when idle, oDone timing.
    always @(negedge clk) begin
        bit   exp_done;
        exp_t e;
        if (reset) begin
            exp_done     = done_pending;
            done_pending = 0;
            if (oValid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid_queue", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rgb", oData, e.rgb);
                    check("latency", cyc, e.stamp);
                    last_data = e.rgb;
                end
                out_cnt++;
                if (out_cnt == FRAME) begin
                    out_cnt      = 0;
                    done_pending = 1;
                end
            end else if (prev_valid) begin
                check("hold", oData, last_data);
            end
            if (oDone || exp_done) check("done", oDone, exp_done);
            if (oDone) done_seen++;
            prev_valid = oValid;
        end
    end

    task automatic send(input logic signed [17:0] y, cb, cr, input logic [23:0] exp);
        exp_t e;
        @(negedge clk);
        iValid = 1'b1;
        iY = y; iCb = cb; iCr = cr;
        e.rgb   = exp;
        e.stamp = cyc + 4;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iValid = 1'b0;
            iY = 18'($urandom); iCb = 18'($urandom); iCr = 18'($urandom);
        end
    endtask

    task automatic send_rand();
        logic signed [17:0] y, cb, cr;
        case ($urandom_range(0, 3))
            0: begin
                y = 18'($urandom); cb = 18'($urandom); cr = 18'($urandom);
            end
            3: begin
                y  = 18'($urandom_range(0, 254) * 512 + 256);
                cb = '0; cr = '0;
            end
            default: begin
                y  = 18'($urandom_range(0, 131071));
                cb = 18'(int'($urandom_range(0, 131071)) - 65536);
                cr = 18'(int'($urandom_range(0, 131071)) - 65536);
            end
        endcase
        send(y, cb, cr, ref_rgb(y, cb, cr));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        iValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_async_data", oData, 0);
        check("rst_async_valid", oValid, 0);
        check("rst_async_done", oDone, 0);
        exp_q.delete();
        out_cnt      = 0;
        done_pending = 0;
        prev_valid   = 0;
        last_data    = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        iValid = 1'b0;
        iY = '0; iCb = '0; iCr = '0;
        repeat (3) @(negedge clk);
        check("reset_data", oData, 0);
        check("reset_valid", oValid, 0);
        check("reset_done", oDone, 0);
        #2 reset = 1'b1;

        // Directed colour points, including clamping and an exact .5 result (100.5 -> 101).
        send(18'sd65536, 18'sd0, 18'sd0, 24'h808080);
        idle(6);
        send(18'sd102400, -18'sd51200, 18'sd0, 24'hC8EA17);
        send(18'sd0, 18'sd0, -18'sd51200, 24'h004700);
        send(18'sd130560, 18'sd65280, 18'sd65280, 24'hFF78FF);
        send(18'sd51456, 18'sd0, 18'sd0, 24'h656565);
        idle(6);
        apply_reset();

        // Two frames: one with random gaps, then one back-to-back with no gap between frames.
        done_seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            send_rand();
            if (i < FRAME - 1) idle($urandom_range(0, 3));
        end
        for (int i = 0; i < FRAME; i++) send_rand();
        idle(8);
        check("two_frames_done", done_seen, 2);

        // Abort a partial frame with pixels in flight; none of them may emerge.
        done_seen = 0;
        for (int i = 0; i < 3; i++) send_rand();
        apply_reset();
        for (int i = 0; i < FRAME; i++) begin
            send_rand();
            idle($urandom_range(0, 3));
        end
        idle(8);
        check("post_reset_done", done_seen, 1);

        // Long random stream with occasional gaps.
        for (int i = 0; i < 1000; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
